// File: rtl/alu_nibble_seq.sv
// Nibble-serial add/subtract sequencer driving an external 4-bit CLA.
// Ports: in_* request, out_* result/flags, cla_* adder nibble interface.
module alu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("alu_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             op_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [WIDTH-1:0] res_nx;
  logic             last;
  logic             ovf_nx;

  // Nibble select/merge as a constant-index mux so no index
  // arithmetic can run past the operand for odd NIB counts.
  always_comb begin
    a_nib  = 4'h0;
    b_nib  = 4'h0;
    res_nx = result_q;
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
        res_nx[4*i +: 4] = cla_sum;
      end
    end
    if (op_q) b_nib = ~b_nib;
  end

  assign last = (cnt == LAST);

  // On the last nibble a_nib/b_nib hold the operand sign bits.
  assign ovf_nx = (a_nib[3] == b_nib[3]) &&
                  (cla_sum[3] != a_nib[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cla_a    = 4'h0;
    cla_b    = 4'h0;
    cla_cin  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        cla_a   = a_nib;
        cla_b   = b_nib;
        cla_cin = carry_q;
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      out_valid <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            op_q    <= in_op;
            cnt     <= '0;
            // Subtract = A + ~B + 1: seed the chain with op.
            carry_q <= in_op;
          end
        end
        RUN: begin
          result_q <= res_nx;
          carry_q  <= cla_cout;
          if (last) begin
            out_carry <= cla_cout;
            out_ovf   <= ovf_nx;
            out_zero  <= (res_nx == '0);
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_result = result_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a behavioural 4-bit CLA.
// Checks results, flags, latency, backpressure, nibble bus, reset.
module tb_alu_nibble_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;
  logic [3:0]   cla_a;
  logic [3:0]   cla_b;
  logic         cla_cin;
  logic [3:0]   cla_sum;
  logic         cla_cout;

  int n_chk  = 0;
  int n_fail = 0;

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .cla_a      (cla_a),
    .cla_b      (cla_b),
    .cla_cin    (cla_cin),
    .cla_sum    (cla_sum),
    .cla_cout   (cla_cout)
  );

  // External adder: purely combinational.
  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b}
                             + {4'b0, cla_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, verify latency and flags; leaves DUT in DONE.
  task automatic run_op(input string tag, input logic op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic c,
                        input logic v, input logic z);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = a;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, 4);
    check({tag, " result"}, out_result, res);
    check({tag, " carry"}, out_carry, c);
    check({tag, " ovf"}, out_ovf, v);
    check({tag, " zero"}, out_zero, z);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid drop"}, out_valid, 0);
    check({tag, " ready back"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    logic [W-1:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #2;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst result", out_result, 0);
    check("rst carry", out_carry, 0);
    check("rst ovf", out_ovf, 0);
    check("rst zero", out_zero, 0);
    check("rst cla_a", cla_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add00ff", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0);
    handshake("add00ff");
    run_op("addffff", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1);
    handshake("addffff");
    run_op("add7fff", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
    handshake("add7fff");
    run_op("sub8000", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0);
    handshake("sub8000");
    run_op("sub0003", 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0);

    // Backpressure: DONE holds despite new requests.
    held = out_result;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a     = W'(16'h1111 * (i + 1));
      @(negedge clk);
      check("bp in_ready", in_ready, 0);
      check("bp valid", out_valid, 1);
      check("bp result", out_result, held);
      check("bp carry", out_carry, 0);
    end
    in_valid = 1'b0;
    handshake("bp");

    // Nibble bus for 0x1234 - 0x0001.
    ea = '{4'h4, 4'h3, 4'h2, 4'h1};
    eb = '{4'hE, 4'hF, 4'hF, 4'hF};
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 1'b1;
    in_a     = 16'h1234;
    in_b     = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bus a%0d", k), cla_a, ea[k]);
      check($sformatf("bus b%0d", k), cla_b, eb[k]);
      check($sformatf("bus c%0d", k), cla_cin, 1);
      @(negedge clk);
    end
    check("bus valid", out_valid, 1);
    check("bus result", out_result, 16'h1233);
    check("bus carry", out_carry, 1);
    check("bus ovf", out_ovf, 0);
    handshake("bus");

    // Reset during RUN cycle 2.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_a     = 16'h5555;
    in_b     = 16'h1111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst in_ready", in_ready, 1);
    check("mrst valid", out_valid, 0);
    check("mrst result", out_result, 0);
    check("mrst carry", out_carry, 0);
    check("mrst cla_a", cla_a, 0);
    check("mrst cla_cin", cla_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mrst no pulse", out_valid, 0);
    end
    run_op("add0001", 1'b0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0);
    handshake("add0001");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
